// File: rtl/ddr2_cmd_scheduler.sv
// Runtime DDR2 command sequencer: closed-page ACTV -> READ/WRTE -> PRCH per access,
// with a periodic precharge-all + auto-refresh that takes priority over requests.
module ddr2_cmd_scheduler #(
   parameter int unsigned T_RCD     = 3,
   parameter int unsigned T_RD_DONE = 4,
   parameter int unsigned T_WR_DONE = 6,
   parameter int unsigned T_RP      = 3,
   parameter int unsigned T_RFC     = 26,
   parameter int unsigned T_REFI    = 780
) (
   input  logic        CLK_n,
   input  logic        RST,
   input  logic        INIT_DONE,
   input  logic        REQ,
   input  logic        REQ_WE,
   input  logic [13:0] REQ_ROW,
   input  logic [9:0]  REQ_COL,
   input  logic [2:0]  REQ_BANK,
   output logic        ACK,
   output logic        REFRESH_BUSY,
   output logic [2:0]  COMMAND_USER,
   output logic [13:0] ADDRESS_USER,
   output logic [2:0]  BANK_USER
);

   typedef enum logic [2:0] {IDLE, ACT_W, RW_W, PRE_W, RPRE_W, REF_W} state_t;
   typedef enum logic [2:0] {
      CMD_NOOP = 3'b111,
      CMD_ACTV = 3'b011,
      CMD_READ = 3'b101,
      CMD_WRTE = 3'b100,
      CMD_PRCH = 3'b010,
      CMD_ARSR = 3'b001
   } cmd_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt, cnt_nxt;
   cmd_t        cmd_nxt;
   logic [13:0] addr_nxt;
   logic [2:0]  bank_nxt;
   logic        ack_nxt, busy_nxt;
   logic        lat_we, lat_we_nxt;
   logic [9:0]  lat_col, lat_col_nxt;
   logic [2:0]  lat_bank, lat_bank_nxt;
   logic [11:0] refi_cnt;
   logic        ref_pend;
   logic        ref_clr;

   // Refresh interval timer; an expiry in the same cycle as ARSR keeps the request pending.
   always_ff @(posedge CLK_n or posedge RST) begin
      if (RST) begin
         refi_cnt <= '0;
         ref_pend <= 1'b0;
      end else begin
         if (ref_clr)
            ref_pend <= 1'b0;
         if (INIT_DONE) begin
            if (refi_cnt == '0) begin
               ref_pend <= 1'b1;
               refi_cnt <= 12'(T_REFI - 1);
            end else begin
               refi_cnt <= refi_cnt - 12'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK_n or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         cnt          <= '0;
         COMMAND_USER <= CMD_NOOP;
         ADDRESS_USER <= '0;
         BANK_USER    <= '0;
         ACK          <= 1'b0;
         REFRESH_BUSY <= 1'b0;
         lat_we       <= 1'b0;
         lat_col      <= '0;
         lat_bank     <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         COMMAND_USER <= cmd_nxt;
         ADDRESS_USER <= addr_nxt;
         BANK_USER    <= bank_nxt;
         ACK          <= ack_nxt;
         REFRESH_BUSY <= busy_nxt;
         lat_we       <= lat_we_nxt;
         lat_col      <= lat_col_nxt;
         lat_bank     <= lat_bank_nxt;
      end
   end

   // Wait states load the full delay and issue on cnt==1; PRE_W/REF_W load one less
   // because the following command is issued from IDLE one cycle later.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cmd_nxt      = CMD_NOOP;
      addr_nxt     = ADDRESS_USER;
      bank_nxt     = BANK_USER;
      ack_nxt      = 1'b0;
      busy_nxt     = REFRESH_BUSY;
      lat_we_nxt   = lat_we;
      lat_col_nxt  = lat_col;
      lat_bank_nxt = lat_bank;
      ref_clr      = 1'b0;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (INIT_DONE) begin
               if (ref_pend) begin
                  cmd_nxt   = CMD_PRCH;
                  addr_nxt  = 14'h400;
                  bank_nxt  = '0;
                  busy_nxt  = 1'b1;
                  cnt_nxt   = 6'(T_RP);
                  state_nxt = RPRE_W;
               end else if (REQ) begin
                  lat_we_nxt   = REQ_WE;
                  lat_col_nxt  = REQ_COL;
                  lat_bank_nxt = REQ_BANK;
                  cmd_nxt      = CMD_ACTV;
                  addr_nxt     = REQ_ROW;
                  bank_nxt     = REQ_BANK;
                  cnt_nxt      = 6'(T_RCD);
                  state_nxt    = ACT_W;
               end
            end
         end
         ACT_W: begin
            if (cnt == 6'd1) begin
               if (lat_we) begin
                  cmd_nxt = CMD_WRTE;
                  cnt_nxt = 6'(T_WR_DONE);
               end else begin
                  cmd_nxt = CMD_READ;
                  cnt_nxt = 6'(T_RD_DONE);
               end
               addr_nxt  = {4'b0000, lat_col};
               bank_nxt  = lat_bank;
               ack_nxt   = 1'b1;
               state_nxt = RW_W;
            end else begin
               cnt_nxt = cnt - 6'd1;
            end
         end
         RW_W: begin
            if (cnt == 6'd1) begin
               cmd_nxt   = CMD_PRCH;
               addr_nxt  = '0;
               bank_nxt  = lat_bank;
               cnt_nxt   = 6'(T_RP - 1);
               state_nxt = PRE_W;
            end else begin
               cnt_nxt = cnt - 6'd1;
            end
         end
         PRE_W: begin
            if (cnt == 6'd1) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 6'd1;
         end
         RPRE_W: begin
            if (cnt == 6'd1) begin
               cmd_nxt   = CMD_ARSR;
               addr_nxt  = 14'h400;
               bank_nxt  = '0;
               ref_clr   = 1'b1;
               cnt_nxt   = 6'(T_RFC - 1);
               state_nxt = REF_W;
            end else begin
               cnt_nxt = cnt - 6'd1;
            end
         end
         REF_W: begin
            if (cnt == 6'd1) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 6'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ddr2_cmd_scheduler.sv
// Self-checking bench for ddr2_cmd_scheduler: schedule-based reference model,
// directed timing scenarios and a randomized request phase.
module tb_ddr2_cmd_scheduler;

   localparam int T_RCD     = 3;
   localparam int T_RD_DONE = 4;
   localparam int T_WR_DONE = 6;
   localparam int T_RP      = 3;
   localparam int T_RFC     = 26;
   localparam int T_REFI    = 780;

   logic        CLK_n = 1'b0;
   logic        RST, INIT_DONE, REQ, REQ_WE;
   logic [13:0] REQ_ROW;
   logic [9:0]  REQ_COL;
   logic [2:0]  REQ_BANK;
   logic        ACK, REFRESH_BUSY;
   logic [2:0]  COMMAND_USER;
   logic [13:0] ADDRESS_USER;
   logic [2:0]  BANK_USER;

   ddr2_cmd_scheduler #(
      .T_RCD(T_RCD), .T_RD_DONE(T_RD_DONE), .T_WR_DONE(T_WR_DONE),
      .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
   ) dut (
      .CLK_n(CLK_n), .RST(RST), .INIT_DONE(INIT_DONE), .REQ(REQ), .REQ_WE(REQ_WE),
      .REQ_ROW(REQ_ROW), .REQ_COL(REQ_COL), .REQ_BANK(REQ_BANK), .ACK(ACK),
      .REFRESH_BUSY(REFRESH_BUSY), .COMMAND_USER(COMMAND_USER),
      .ADDRESS_USER(ADDRESS_USER), .BANK_USER(BANK_USER)
   );

   always #5 CLK_n = ~CLK_n;

   localparam logic [2:0] NOOP = 3'b111, ACTV = 3'b011, READ = 3'b101,
                          WRTE = 3'b100, PRCH = 3'b010, ARSR = 3'b001;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: each decision lays out its whole future command timeline.
   int          edge_n = 0;
   int          free_at = 0;
   int          busy_until = -1;
   logic        m_pend = 1'b0;
   int unsigned n_init = 0;
   logic [19:0] sched [int];

   typedef struct { int e; logic [2:0] cmd; logic [13:0] addr; logic [2:0] bank; } obs_t;
   obs_t obs_q[$];
   int   ack_cnt = 0;
   int   busy_cnt = 0;

   always @(posedge CLK_n) begin : monitor
      logic [19:0] ev;
      logic        rst_s;
      int          d;
      edge_n++;
      rst_s = RST;
      if (rst_s) begin
         sched.delete();
         m_pend     = 1'b0;
         n_init     = 0;
         free_at    = edge_n + 1;
         busy_until = -1;
         ev         = {NOOP, 17'h0};
      end else begin
         if (INIT_DONE && edge_n >= free_at) begin
            if (m_pend) begin
               sched[edge_n]        = {PRCH, 14'h400, 3'd0};
               sched[edge_n + T_RP] = {ARSR, 14'h400, 3'd0};
               free_at    = edge_n + T_RP + T_RFC;
               busy_until = free_at - 1;
            end else if (REQ) begin
               d = REQ_WE ? T_WR_DONE : T_RD_DONE;
               sched[edge_n]             = {ACTV, REQ_ROW, REQ_BANK};
               sched[edge_n + T_RCD]     = {(REQ_WE ? WRTE : READ), 4'b0000, REQ_COL, REQ_BANK};
               sched[edge_n + T_RCD + d] = {PRCH, 14'h0, REQ_BANK};
               free_at = edge_n + T_RCD + d + T_RP;
            end
         end
         ev = sched.exists(edge_n) ? sched[edge_n] : {NOOP, 17'h0};
         if (ev[19:17] == ARSR) m_pend = 1'b0;
         if (INIT_DONE) begin
            if (n_init % T_REFI == 0) m_pend = 1'b1;
            n_init++;
         end
      end
      #1;
      chk("cmd", COMMAND_USER, ev[19:17]);
      chk("ack", ACK, (ev[19:17] == READ || ev[19:17] == WRTE));
      chk("busy", REFRESH_BUSY, (!rst_s && edge_n <= busy_until));
      if (rst_s) begin
         chk("rst_addr", ADDRESS_USER, 14'h0);
         chk("rst_bank", BANK_USER, 3'h0);
      end else if (ev[19:17] != NOOP) begin
         chk("addr", ADDRESS_USER, ev[16:3]);
         chk("bank", BANK_USER, ev[2:0]);
      end
      if (COMMAND_USER != NOOP) obs_q.push_back('{edge_n, COMMAND_USER, ADDRESS_USER, BANK_USER});
      if (ACK) ack_cnt++;
      if (REFRESH_BUSY) busy_cnt++;
      sched.delete(edge_n);
   end

   task automatic chk_obs(input string nm, input int i, input logic [2:0] c,
                          input logic [13:0] a, input logic [2:0] b, input int ee);
      if (i < obs_q.size()) begin
         chk({nm, "_cmd"}, obs_q[i].cmd, c);
         chk({nm, "_addr"}, obs_q[i].addr, a);
         chk({nm, "_bank"}, obs_q[i].bank, b);
         chk({nm, "_edge"}, obs_q[i].e, ee);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(edge_n + 1 >= free_at && !m_pend && edge_n >= busy_until) && k < 400) begin
         @(negedge CLK_n);
         k++;
      end
      chk("wait_idle_bound", (k < 400), 1'b1);
   endtask

   task automatic wait_ack();
      int k = 0;
      do begin
         @(negedge CLK_n);
         k++;
      end while (!ACK && k < 200);
      chk("ack_bound", (k < 200), 1'b1);
   endtask

   task automatic send_req(input logic we, input logic [13:0] row, input logic [9:0] col,
                           input logic [2:0] bank);
      REQ_WE = we; REQ_ROW = row; REQ_COL = col; REQ_BANK = bank; REQ = 1'b1;
      wait_ack();
      REQ = 1'b0;
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int t, k;
      RST = 1'b1; INIT_DONE = 1'b0; REQ = 1'b0; REQ_WE = 1'b0;
      REQ_ROW = '0; REQ_COL = '0; REQ_BANK = '0;
      repeat (3) @(negedge CLK_n);
      RST = 1'b0;

      // Idle while the initializer has not finished
      repeat (2000) @(negedge CLK_n);
      chk("noinit_cmds", obs_q.size(), 0);
      chk("noinit_acks", ack_cnt, 0);
      chk("noinit_busy", busy_cnt, 0);

      INIT_DONE = 1'b1;
      repeat (3) @(negedge CLK_n);
      wait_idle();

      // Single read
      obs_q.delete();
      t = edge_n;
      send_req(1'b0, 14'h1234, 10'h155, 3'd3);
      wait_idle();
      chk("rd_count", obs_q.size(), 3);
      chk_obs("rd_actv", 0, ACTV, 14'h1234, 3'd3, t + 1);
      chk_obs("rd_read", 1, READ, 14'h0155, 3'd3, t + 4);
      chk_obs("rd_prch", 2, PRCH, 14'h0000, 3'd3, t + 8);

      // Two writes back-to-back with REQ held high
      obs_q.delete();
      ack_cnt = 0;
      t = edge_n;
      REQ_WE = 1'b1; REQ_ROW = 14'h0ABC; REQ_COL = 10'h3C3; REQ_BANK = 3'd1; REQ = 1'b1;
      wait_ack();
      REQ_ROW = 14'h3001; REQ_COL = 10'h021; REQ_BANK = 3'd6;
      wait_ack();
      REQ = 1'b0;
      wait_idle();
      chk("wr2_count", obs_q.size(), 6);
      chk("wr2_acks", ack_cnt, 2);
      chk_obs("wr2_actv1", 0, ACTV, 14'h0ABC, 3'd1, t + 1);
      chk_obs("wr2_wrte1", 1, WRTE, 14'h03C3, 3'd1, t + 4);
      chk_obs("wr2_prch1", 2, PRCH, 14'h0000, 3'd1, t + 10);
      chk_obs("wr2_actv2", 3, ACTV, 14'h3001, 3'd6, t + 13);
      chk_obs("wr2_wrte2", 4, WRTE, 14'h0021, 3'd6, t + 16);

      // Refresh due in the same cycle a request is sampled
      k = 0;
      while (!m_pend && k < T_REFI + 50) begin @(negedge CLK_n); k++; end
      chk("pend_bound", m_pend, 1'b1);
      obs_q.delete();
      busy_cnt = 0;
      t = edge_n + 1;
      send_req(1'b0, 14'h2222, 10'h011, 3'd2);
      wait_idle();
      chk("refreq_count", obs_q.size(), 5);
      chk("refreq_busy", busy_cnt, 29);
      chk_obs("refreq_prch", 0, PRCH, 14'h0400, 3'd0, t);
      chk_obs("refreq_arsr", 1, ARSR, 14'h0400, 3'd0, t + 3);
      chk_obs("refreq_actv", 2, ACTV, 14'h2222, 3'd2, t + 29);

      // Refresh falling due while the access waits in ACT_W
      k = 0;
      while (!(edge_n + 1 >= free_at && !m_pend && edge_n >= busy_until &&
               n_init % T_REFI == T_REFI - 1) && k < 2 * T_REFI) begin
         @(negedge CLK_n); k++;
      end
      chk("midref_bound", (k < 2 * T_REFI), 1'b1);
      obs_q.delete();
      t = edge_n + 1;
      send_req(1'b0, 14'h1555, 10'h2AA, 3'd4);
      wait_idle();
      chk("midref_count", obs_q.size(), 5);
      chk_obs("midref_actv", 0, ACTV, 14'h1555, 3'd4, t);
      chk_obs("midref_read", 1, READ, 14'h02AA, 3'd4, t + 3);
      chk_obs("midref_prch", 2, PRCH, 14'h0000, 3'd4, t + 7);
      chk_obs("midref_rprch", 3, PRCH, 14'h0400, 3'd0, t + 10);
      chk_obs("midref_arsr", 4, ARSR, 14'h0400, 3'd0, t + 13);

      // Reset pulse one cycle after ACTV
      obs_q.delete();
      ack_cnt = 0;
      REQ_WE = 1'b0; REQ_ROW = 14'h2AAA; REQ_COL = 10'h3FF; REQ_BANK = 3'd7; REQ = 1'b1;
      k = 0;
      while (obs_q.size() == 0 && k < 50) begin @(negedge CLK_n); k++; end
      chk("rst_actv_seen", obs_q.size(), 1);
      @(negedge CLK_n);
      RST = 1'b1;
      #1;
      chk("rst_now_cmd", COMMAND_USER, NOOP);
      chk("rst_now_ack", ACK, 1'b0);
      @(negedge CLK_n);
      RST = 1'b0;
      chk("rst_no_read", obs_q.size(), 1);
      chk("rst_no_ack", ack_cnt, 0);
      obs_q.delete();
      t = edge_n;
      REQ_ROW = 14'h0F0F; REQ_COL = 10'h0AA; REQ_BANK = 3'd5;
      wait_ack();
      REQ = 1'b0;
      wait_idle();
      chk("rst_new_acks", ack_cnt, 1);
      chk_obs("rst_new_actv", 0, ACTV, 14'h0F0F, 3'd5, t + 1);
      chk_obs("rst_new_read", 1, READ, 14'h00AA, 3'd5, t + 4);
      chk_obs("rst_new_rprch", 3, PRCH, 14'h0400, 3'd0, t + 11);

      // Randomized traffic with INIT_DONE dropouts
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 5) == 0) INIT_DONE = 1'b0;
         repeat ($urandom_range(0, 12)) @(negedge CLK_n);
         INIT_DONE = 1'b1;
         send_req(1'($urandom), 14'($urandom), 10'($urandom), 3'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            INIT_DONE = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge CLK_n);
            INIT_DONE = 1'b1;
         end
      end
      wait_idle();
      repeat (2) @(negedge CLK_n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
